// File: rtl/vram_write_queue.sv
`default_nettype none
// ============================================================================
// Module      : vram_write_queue
// Description : Buffers CPU writes and drains them onto the VRAM write bus
//               only while the video timing block reports a writable window.
// Revision    : 1.0 - initial release
// ============================================================================

`ifndef VRAM_ADDR_WIDTH
`define VRAM_ADDR_WIDTH 12
`endif

module vram_write_queue #(
  parameter int ADDR_WIDTH = `VRAM_ADDR_WIDTH,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cpu_wr_valid,
  output logic                  cpu_wr_ready,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [7:0]            cpu_data,
  input  logic                  flush,
  input  logic                  writable,
  output logic                  vram_wen,
  output logic [ADDR_WIDTH-1:0] address,
  output logic [7:0]            data,
  output logic [DEPTH_LOG2:0]   pending,
  output logic                  late,
  output logic [7:0]            frame_writes
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_COUNT = (DEPTH_LOG2 + 1)'(DEPTH);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_PENDING = 2'd1;
  localparam logic [1:0] ST_DRAIN   = 2'd2;

  logic [ADDR_WIDTH+7:0] mem [DEPTH];
  logic [ADDR_WIDTH+7:0] head;
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2:0]   count;
  logic [DEPTH_LOG2:0]   count_next;
  logic [1:0]            state;
  logic [1:0]            state_next;
  logic                  late_next;
  logic                  writable_q;
  logic                  empty;
  logic                  full;
  logic                  push;
  logic                  pop;
  logic                  window_open;

  assign empty        = (count == '0);
  assign full         = (count == FULL_COUNT);
  assign cpu_wr_ready = !full && !flush;
  assign push         = cpu_wr_valid && cpu_wr_ready;
  assign vram_wen     = writable && !empty && !flush;
  assign pop          = vram_wen;
  assign pending      = count;
  assign window_open  = writable && !writable_q;

  // Head is read asynchronously; the bus idles at zero when nothing is queued.
  assign head    = mem[rd_ptr];
  assign address = empty ? '0 : head[ADDR_WIDTH+7:8];
  assign data    = empty ? '0 : head[7:0];

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {cpu_addr, cpu_data};
    end
  end

  always_comb begin
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + (DEPTH_LOG2 + 1)'(1);
      2'b01:   count_next = count - (DEPTH_LOG2 + 1)'(1);
      default: count_next = count;
    endcase
  end

  always_comb begin
    state_next = state;
    late_next  = late;
    if (flush) begin
      state_next = ST_IDLE;
      late_next  = 1'b0;
    end else if (count_next == '0) begin
      state_next = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:    state_next = writable ? ST_DRAIN : ST_PENDING;
        ST_PENDING: state_next = writable ? ST_DRAIN : ST_PENDING;
        ST_DRAIN: begin
          if (!writable) begin
            state_next = ST_PENDING;
            late_next  = 1'b1;
          end
        end
        default:    state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      state      <= ST_IDLE;
      late       <= 1'b0;
      writable_q <= 1'b0;
    end else begin
      writable_q <= writable;
      state      <= state_next;
      late       <= late_next;
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        count <= count_next;
        if (push) begin
          wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
        end
        if (pop) begin
          rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
        end
      end
    end
  end

  // A write issued in the cycle the window opens counts as the first of the new window.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      frame_writes <= 8'd0;
    end else if (window_open) begin
      frame_writes <= {7'd0, vram_wen};
    end else if (vram_wen && (frame_writes != 8'hFF)) begin
      frame_writes <= frame_writes + 8'd1;
    end
  end

endmodule

`default_nettype wire
